// File: rtl/sync_fifo_p.sv
// ---------------------------------------------------------------------------
// sync_fifo_p : parametrised single-clock FIFO
//
// Parameters
//   DATA_W     data word width in bits (>= 1)
//   DEPTH      number of entries, power of two, >= 4
//   AF_THRESH  almost_full asserts when occupancy >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty asserts when occupancy <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr_en/wdata  write request and data
//   rd_en        read request (pop acknowledge in FWFT mode)
//   rdata        read data
//   full/empty/almost_full/almost_empty  status decoded from occupancy
//   overflow     one-cycle pulse after a write attempted while full
//   underflow    one-cycle pulse after a read attempted while empty
//   fifo_counter current occupancy, 0..DEPTH
//
// Build option
//   FIFO_FWFT_EN  when defined, rdata shows the head word combinationally
//                 (first-word-fall-through); otherwise rdata is a register
//                 loaded on each accepted read and reset to zero.
// ---------------------------------------------------------------------------
module sync_fifo_p #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rdata,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        overflow,
  output logic                        underflow,
  output logic [$clog2(DEPTH):0]      fifo_counter
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              wa;
  logic              ra;

  // Status comes only from the count register, so it never glitches and
  // the accept decisions below always see the pre-edge state.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign fifo_counter = count;

  // When full, a simultaneous read still succeeds and the write is dropped;
  // when empty, the write succeeds and the read is dropped (no bypass).
  assign wa = wr_en && !full;
  assign ra = rd_en && !empty;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wa) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wa) begin
        wptr <= wptr + AW'(1);
      end
      if (ra) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({wa, ra})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always visible; rd_en pops it. Undefined while empty.
  assign rdata = mem[rptr];
`else
  // Registered read: value appears the cycle after the accepted read and
  // holds otherwise, including while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (ra) begin
      rdata <= mem[rptr];
    end
  end
`endif

endmodule

// File: doc/sync_fifo_p.md
# sync_fifo_p

Parametrised single-clock FIFO, the next generation of the team's 8-bit/16-entry FIFO block. Data width, depth and almost-full/almost-empty thresholds are configurable, and the block adds sticky-free overflow/underflow error pulses and an occupancy counter. An optional first-word-fall-through read mode is available. It sits between a producer and a consumer in the same clock domain and is driven from the existing clocking-block test environment.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- Derived: AW = $clog2(DEPTH), CW = AW+1
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request
- wdata  input  DATA_W  write data, sampled with wr_en
- rd_en  input  1  read request
- rdata  output  DATA_W  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_THRESH
- almost_empty  output  1  count ≤ AE_THRESH
- overflow  output  1  one-cycle pulse: write attempted while full
- underflow  output  1  one-cycle pulse: read attempted while empty
- fifo_counter  output  CW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH×DATA_W register array. The write and read pointers are AW bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is held in a CW-bit count register.
- Write accepted (wa) = wr_en && !full. Read accepted (ra) = rd_en && !empty. Both use the registered flags present before the edge.
- On wa: mem[wptr] ← wdata, wptr++.
- On ra: rptr++.
- count update: +1 on wa only, −1 on ra only, unchanged when both or neither occur.
- While full, wr_en && rd_en: the read is accepted and the write is dropped; overflow pulses and count becomes DEPTH-1.
- While empty, wr_en && rd_en: the write is accepted and the read is dropped (no bypass); underflow pulses and count becomes 1.
- Dropped accesses never modify memory, pointers or count.
- overflow is registered as (wr_en && full); underflow as (rd_en && empty). Each is high for exactly the cycle after the offending edge.
- full, empty, almost_full, almost_empty and fifo_counter are decoded from the count register only, so they are glitch-free.
- Non-FWFT rdata: registered. On ra, rdata ← mem[rptr]. It holds its value otherwise, including across empty.

## Timing
- Reset (rst_n low, asynchronous) forces: wptr=0, rptr=0, count=0, rdata=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0, fifo_counter=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored words immediately. The first edge after rst_n deasserts behaves as an ordinary cycle.
- Write to flag latency: empty deasserts and fifo_counter increments in the cycle after the accepting edge.
- Read latency (non-FWFT): data is valid on rdata in the cycle after the ra edge.
- Sustained simultaneous read and write at 1 word/cycle is supported at any occupancy 1..DEPTH-1.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rdata = mem[rptr] combinationally and is valid whenever empty=0.
  - The first written word appears on rdata in the cycle after its write edge.
  - rd_en acts as an acknowledge that pops the word currently shown on rdata.
  - rdata is don't-care while empty.
- FIFO_FWFT_EN undefined: registered-read behaviour as described in Operation, with rdata reset to 0.

## Test plan
- Reset then idle: all outputs equal their reset values. Toggle rst_n low mid-stream with count=5: count→0 and empty=1 immediately, without waiting for a clock edge.
- Write 16 words 0x00..0x0F with defaults: full=1, fifo_counter=16, almost_full=1 from count=14. A 17th write gives overflow=1 for one cycle and count stays 16.
- Read all 16 words (non-FWFT): rdata=0x00..0x0F, each one cycle after its rd_en edge. Empty=1 after the last read; a further rd_en gives an underflow pulse and rdata holds 0x0F.
- Simultaneous wr_en/rd_en at count=0: count becomes 1 and underflow pulses. At count=16: count becomes 15, overflow pulses, and the dropped word never appears on rdata.
- Wrap-around: perform 40 mixed random write/read transactions with DEPTH=8, DATA_W=12, AF_THRESH=6, AE_THRESH=1. Output order must match a reference queue, and the flags must match count at every cycle.
- With FIFO_FWFT_EN: write 0xA5 into an empty FIFO; rdata=0xA5 and empty=0 in the next cycle, with no rd_en. After rd_en, empty=1.
